// File: rtl/csr_trap_ctrl.sv
// Machine-mode CSR file and trap/MRET redirect sequencer.
// Ports: decoder strobes + CSR addr/wdata in, irq levels in;
// csr_rdata/trap_kill comb out, epc_taken/epc/flush registered.
module csr_trap_ctrl #(
  parameter logic [31:0] RESET_MTVEC  = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid,
  input  logic [31:0] pc_ex,
  input  logic        csr_rd,
  input  logic        csr_wr,
  input  logic        is_mret,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  input  logic        ext_irq,
  input  logic        timer_irq,
  output logic [31:0] csr_rdata,
  output logic        trap_kill,
  output logic        epc_taken,
  output logic [31:0] epc,
  output logic        flush
);

  typedef enum logic [1:0] {
    IDLE,
    REDIR,
    FLUSH
  } state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        m_ie, m_pie;
  logic        meie, mtie;
  logic        meip, mtip;
  logic [31:2] mtvec, mepc;
  logic [31:0] mcause;
  logic        idle, irq_ext, irq_tmr;
  logic        irq_take, mret_take, wr_en;
  logic        unused;

  assign unused = ^pc_ex[1:0];

  assign idle      = (state == IDLE);
  assign irq_ext   = meip & meie;
  assign irq_tmr   = mtip & mtie;
  assign irq_take  = idle & inst_valid & m_ie
                   & (irq_ext | irq_tmr);
  assign mret_take = idle & inst_valid & is_mret & ~irq_take;
  assign wr_en     = idle & inst_valid & csr_wr & ~irq_take;
  assign trap_kill = irq_take;

  // Read mux returns pre-write values so CSRRW swaps.
  always_comb begin
    csr_rdata = 32'h0;
    if (csr_rd && inst_valid) begin
      case (csr_addr)
        12'h300: csr_rdata = {24'h0, m_pie, 3'b0, m_ie, 3'b0};
        12'h304: csr_rdata = {20'h0, meie, 3'b0, mtie, 7'b0};
        12'h305: csr_rdata = {mtvec, 2'b00};
        12'h341: csr_rdata = {mepc, 2'b00};
        12'h342: csr_rdata = mcause;
        12'h344: csr_rdata = {20'h0, meip, 3'b0, mtip, 7'b0};
        default: csr_rdata = 32'h0;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (irq_take || mret_take) state_nxt = REDIR;
      end
      REDIR: begin
        cnt_nxt   = FLUSH_LOAD;
        state_nxt = (FLUSH_LOAD != 4'd0) ? FLUSH : IDLE;
      end
      FLUSH: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt_nxt == 4'd0) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      epc_taken <= 1'b0;
      flush     <= 1'b0;
      epc       <= 32'h0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      epc_taken <= (state_nxt == REDIR);
      flush     <= (state_nxt != IDLE);
      if (irq_take)
        epc <= {mtvec, 2'b00};
      else if (mret_take)
        epc <= {mepc, 2'b00};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ie   <= 1'b0;
      m_pie  <= 1'b0;
      meie   <= 1'b0;
      mtie   <= 1'b0;
      meip   <= 1'b0;
      mtip   <= 1'b0;
      mtvec  <= RESET_MTVEC[31:2];
      mepc   <= 30'h0;
      mcause <= 32'h0;
    end else begin
      meip <= ext_irq;
      mtip <= timer_irq;
      if (wr_en) begin
        case (csr_addr)
          12'h300: begin
            m_ie  <= csr_wdata[3];
            m_pie <= csr_wdata[7];
          end
          12'h304: begin
            mtie <= csr_wdata[7];
            meie <= csr_wdata[11];
          end
          12'h305: mtvec  <= csr_wdata[31:2];
          12'h341: mepc   <= csr_wdata[31:2];
          12'h342: mcause <= csr_wdata;
          default: ;
        endcase
      end
      if (irq_take) begin
        mepc   <= pc_ex[31:2];
        mcause <= irq_ext ? 32'h8000_000B : 32'h8000_0007;
        m_pie  <= m_ie;
        m_ie   <= 1'b0;
      end else if (mret_take) begin
        m_ie  <= m_pie;
        m_pie <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Directed bench for csr_trap_ctrl: CSR access, traps,
// MRET, priority and a FLUSH_CYCLES=4 instance with reset.
module tb_csr_trap_ctrl;

  logic        clk;
  logic        rst, rst4;
  logic        inst_valid;
  logic [31:0] pc_ex;
  logic        csr_rd, csr_wr, is_mret;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        ext_irq, timer_irq;
  logic [31:0] csr_rdata, rdata4;
  logic        trap_kill, trap_kill4;
  logic        epc_taken, epc_taken4;
  logic [31:0] epc, epc4;
  logic        flush, flush4;

  int n_chk;
  int n_err;
  int cnt_f, cnt_e;

  csr_trap_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .inst_valid (inst_valid),
    .pc_ex      (pc_ex),
    .csr_rd     (csr_rd),
    .csr_wr     (csr_wr),
    .is_mret    (is_mret),
    .csr_addr   (csr_addr),
    .csr_wdata  (csr_wdata),
    .ext_irq    (ext_irq),
    .timer_irq  (timer_irq),
    .csr_rdata  (csr_rdata),
    .trap_kill  (trap_kill),
    .epc_taken  (epc_taken),
    .epc        (epc),
    .flush      (flush)
  );

  csr_trap_ctrl #(
    .RESET_MTVEC  (32'h0000_0103),
    .FLUSH_CYCLES (4)
  ) dut4 (
    .clk        (clk),
    .rst        (rst4),
    .inst_valid (inst_valid),
    .pc_ex      (pc_ex),
    .csr_rd     (csr_rd),
    .csr_wr     (csr_wr),
    .is_mret    (is_mret),
    .csr_addr   (csr_addr),
    .csr_wdata  (csr_wdata),
    .ext_irq    (ext_irq),
    .timer_irq  (timer_irq),
    .csr_rdata  (rdata4),
    .trap_kill  (trap_kill4),
    .epc_taken  (epc_taken4),
    .epc        (epc4),
    .flush      (flush4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [11:0] a,
                           input logic [31:0] d);
    csr_addr   = a;
    csr_wdata  = d;
    csr_wr     = 1'b1;
    csr_rd     = 1'b1;
    inst_valid = 1'b1;
    tick();
    csr_wr     = 1'b0;
    csr_rd     = 1'b0;
    inst_valid = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input bit use4,
                        input logic [11:0] a,
                        input logic [31:0] exp);
    csr_addr   = a;
    csr_rd     = 1'b1;
    inst_valid = 1'b1;
    #1;
    check(tag, use4 ? rdata4 : csr_rdata, exp);
    csr_rd     = 1'b0;
    inst_valid = 1'b0;
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b1; rst4 = 1'b1;
    inst_valid = 0; pc_ex = 0;
    csr_rd = 0; csr_wr = 0; is_mret = 0;
    csr_addr = 0; csr_wdata = 0;
    ext_irq = 0; timer_irq = 0;
    #2;
    check("rst_epc_taken", 32'(epc_taken), 32'h0);
    check("rst_flush", 32'(flush), 32'h0);
    check("rst_epc", epc, 32'h0);
    check("rst_trap_kill", 32'(trap_kill), 32'h0);
    rd_chk("rst_mstatus", 0, 12'h300, 32'h0);
    rd_chk("rst_mtvec", 0, 12'h305, 32'h0);
    @(negedge clk);
    rst = 1'b0; rst4 = 1'b0;
    tick();

    // CSR access basics
    csr_write(12'h305, 32'h1234_5677);
    rd_chk("mtvec_mask", 0, 12'h305, 32'h1234_5674);
    rd_chk("unimpl_rd", 0, 12'h7C0, 32'h0);
    csr_write(12'h344, 32'hFFFF_FFFF);
    rd_chk("mip_ro", 0, 12'h344, 32'h0);

    // external interrupt entry
    csr_write(12'h304, 32'h0000_0800);
    csr_write(12'h300, 32'h0000_0008);
    rd_chk("mstatus_mie", 0, 12'h300, 32'h8);
    ext_irq = 1'b1;
    tick();
    rd_chk("mip_meip", 0, 12'h344, 32'h800);
    pc_ex = 32'h40;
    inst_valid = 1'b1;
    #1;
    check("irq_kill", 32'(trap_kill), 32'h1);
    tick();
    inst_valid = 1'b0;
    ext_irq = 1'b0;
    check("irq_epc_taken", 32'(epc_taken), 32'h1);
    check("irq_epc", epc, 32'h1234_5674);
    check("irq_flush1", 32'(flush), 32'h1);
    tick();
    check("irq_taken_drop", 32'(epc_taken), 32'h0);
    check("irq_flush2", 32'(flush), 32'h1);
    tick();
    check("irq_flush_end", 32'(flush), 32'h0);
    rd_chk("irq_mepc", 0, 12'h341, 32'h40);
    rd_chk("irq_mcause", 0, 12'h342, 32'h8000_000B);
    rd_chk("irq_mstatus", 0, 12'h300, 32'h80);

    // MRET; is_mret held through REDIR/FLUSH
    csr_write(12'h341, 32'h0000_0103);
    rd_chk("mepc_mask", 0, 12'h341, 32'h100);
    is_mret = 1'b1;
    inst_valid = 1'b1;
    tick();
    check("mret_taken", 32'(epc_taken), 32'h1);
    check("mret_epc", epc, 32'h100);
    tick();
    check("mret_taken_drop", 32'(epc_taken), 32'h0);
    check("mret_flush2", 32'(flush), 32'h1);
    tick();
    is_mret = 1'b0;
    inst_valid = 1'b0;
    check("mret_ign_taken", 32'(epc_taken), 32'h0);
    check("mret_ign_flush", 32'(flush), 32'h0);
    rd_chk("mret_mstatus", 0, 12'h300, 32'h88);

    // both pending, csr_wr collides with irq_take
    csr_write(12'h304, 32'h0000_0880);
    ext_irq = 1'b1;
    timer_irq = 1'b1;
    tick();
    csr_addr = 12'h300;
    csr_wdata = 32'h0000_0008;
    csr_wr = 1'b1;
    inst_valid = 1'b1;
    pc_ex = 32'h200;
    #1;
    check("coll_kill", 32'(trap_kill), 32'h1);
    tick();
    csr_wr = 1'b0;
    inst_valid = 1'b0;
    ext_irq = 1'b0;
    check("coll_taken", 32'(epc_taken), 32'h1);
    tick();
    tick();
    rd_chk("prio_mcause", 0, 12'h342, 32'h8000_000B);
    rd_chk("coll_mstatus", 0, 12'h300, 32'h80);
    rd_chk("coll_mepc", 0, 12'h341, 32'h200);
    is_mret = 1'b1;
    inst_valid = 1'b1;
    tick();
    is_mret = 1'b0;
    inst_valid = 1'b0;
    check("mret2_epc", epc, 32'h200);
    tick();
    tick();
    pc_ex = 32'h300;
    inst_valid = 1'b1;
    #1;
    check("tmr_kill", 32'(trap_kill), 32'h1);
    tick();
    inst_valid = 1'b0;
    timer_irq = 1'b0;
    tick();
    tick();
    rd_chk("tmr_mcause", 0, 12'h342, 32'h8000_0007);
    rd_chk("tmr_mepc", 0, 12'h341, 32'h300);

    // FLUSH_CYCLES=4 instance
    rst4 = 1'b1;
    #2;
    rst4 = 1'b0;
    tick();
    rd_chk("f4_mtvec", 1, 12'h305, 32'h100);
    csr_write(12'h304, 32'h0000_0800);
    csr_write(12'h300, 32'h0000_0008);
    ext_irq = 1'b1;
    tick();
    pc_ex = 32'h44;
    inst_valid = 1'b1;
    tick();
    inst_valid = 1'b0;
    ext_irq = 1'b0;
    check("f4_epc", epc4, 32'h100);
    cnt_f = 0;
    cnt_e = 0;
    for (int i = 0; i < 8; i++) begin
      cnt_f += int'(flush4);
      cnt_e += int'(epc_taken4);
      tick();
    end
    check("f4_flush_cnt", 32'(cnt_f), 32'd4);
    check("f4_taken_cnt", 32'(cnt_e), 32'd1);

    csr_write(12'h300, 32'h0000_0008);
    ext_irq = 1'b1;
    tick();
    inst_valid = 1'b1;
    tick();
    inst_valid = 1'b0;
    ext_irq = 1'b0;
    tick();
    tick();
    check("f4_flush3", 32'(flush4), 32'h1);
    rst4 = 1'b1;
    #1;
    check("f4_rst_flush", 32'(flush4), 32'h0);
    check("f4_rst_taken", 32'(epc_taken4), 32'h0);
    check("f4_rst_epc", epc4, 32'h0);
    check("f4_rst_kill", 32'(trap_kill4), 32'h0);
    #2;
    rst4 = 1'b0;
    tick();
    check("f4_idle_flush", 32'(flush4), 32'h0);
    rd_chk("f4_rst_mstatus", 1, 12'h300, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
